// File: rtl/store_agu_pipe.sv
// store_agu_pipe
//   Multi-lane store address-generation stage between issue and the store
//   queue. Each lane registers an issued store, computes addr = base + imm,
//   lane-aligns data and byte mask, and presents a one-hot SQ resolve mask.
//   A two-slot (MAIN + SKID) buffer per lane keeps in_ready registered and
//   guarantees no store is lost under SQ back-pressure.
//
// Optional feature: define STORE_MISALIGN_CHK_EN to add out_misalign and
//   force the byte mask of misaligned stores to zero.
//
// Ports (per-lane fields packed lane 0 in the LSBs):
//   clock, reset (sync, active-low), flush (squash all in-flight stores)
//   in_valid/in_ready, in_base, in_imm, in_data, in_size, in_sq_idx : issue side
//   out_valid/out_ready, out_addr, out_data, out_byte_mask, out_sq_mask : SQ side
//   out_misalign : misaligned-access flag (STORE_MISALIGN_CHK_EN only)
module store_agu_pipe #(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 32,
  parameter int SQ_DEPTH  = 8,
  localparam int BPW      = DATA_W / 8,
  localparam int SQ_IDX_W = $clog2(SQ_DEPTH)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_LANES-1:0]          in_valid,
  output logic [NUM_LANES-1:0]          in_ready,
  input  logic [NUM_LANES*DATA_W-1:0]   in_base,
  input  logic [NUM_LANES*DATA_W-1:0]   in_imm,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  input  logic [NUM_LANES*2-1:0]        in_size,
  input  logic [NUM_LANES*SQ_IDX_W-1:0] in_sq_idx,
  output logic [NUM_LANES-1:0]          out_valid,
  input  logic [NUM_LANES-1:0]          out_ready,
  output logic [NUM_LANES*DATA_W-1:0]   out_addr,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [NUM_LANES*BPW-1:0]      out_byte_mask,
  output logic [NUM_LANES*SQ_DEPTH-1:0] out_sq_mask
`ifdef STORE_MISALIGN_CHK_EN
  ,
  output logic [NUM_LANES-1:0]          out_misalign
`endif
);

  localparam int OFF_W = $clog2(BPW);
  localparam logic [3:0] BPW4 = 4'(BPW);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [BPW-1:0]      mask;
    logic [SQ_IDX_W-1:0] idx;
`ifdef STORE_MISALIGN_CHK_EN
    logic                mis;
`endif
  } payload_t;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_state_t state_q, state_d;
    payload_t    main_q, main_d, skid_q, skid_d, incoming;
    logic        accept, drain, main_valid;
    logic [DATA_W-1:0] addr;
    logic [OFF_W-1:0]  offset;
    logic [3:0]        sz_bytes;
    logic [7:0]        raw_mask;
    logic [BPW-1:0]    base_mask;
    logic              mis;

    // Payload is fully resolved on entry so the output side is pure registers.
    always_comb begin
      addr     = in_base[l*DATA_W +: DATA_W] + in_imm[l*DATA_W +: DATA_W];
      offset   = addr[OFF_W-1:0];
      sz_bytes = 4'd1 << in_size[l*2 +: 2];
      unique case (in_size[l*2 +: 2])
        2'b00:   raw_mask = 8'h01;
        2'b01:   raw_mask = 8'h03;
        2'b10:   raw_mask = 8'h0F;
        default: raw_mask = 8'hFF;
      endcase
      // Sizes wider than the datapath produce an empty mask.
      base_mask = (sz_bytes > BPW4) ? '0 : BPW'(raw_mask);
      mis = (sz_bytes > BPW4) || ((4'(offset) & (sz_bytes - 4'd1)) != 4'd0);
      incoming      = '0;
      incoming.addr = addr;
      incoming.data = in_data[l*DATA_W +: DATA_W] << {offset, 3'b000};
      incoming.mask = base_mask << offset;
      incoming.idx  = in_sq_idx[l*SQ_IDX_W +: SQ_IDX_W];
`ifdef STORE_MISALIGN_CHK_EN
      incoming.mis  = mis;
      if (mis) incoming.mask = '0;
`endif
    end

    assign main_valid  = (state_q != EMPTY);
    assign in_ready[l] = reset && !flush && (state_q != FULL);
    assign accept      = in_valid[l] && in_ready[l];
    assign drain       = main_valid && out_ready[l];

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          main_d  = incoming;
        end
        ONE: begin
          if (drain && accept) begin
            main_d = incoming;
          end else if (drain) begin
            state_d = EMPTY;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = incoming;
          end
        end
        FULL: if (drain) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    assign out_valid[l]                     = main_valid;
    assign out_addr[l*DATA_W +: DATA_W]     = main_valid ? main_q.addr : '0;
    assign out_data[l*DATA_W +: DATA_W]     = main_valid ? main_q.data : '0;
    assign out_byte_mask[l*BPW +: BPW]      = main_valid ? main_q.mask : '0;
    assign out_sq_mask[l*SQ_DEPTH +: SQ_DEPTH] =
      main_valid ? (SQ_DEPTH'(1) << main_q.idx) : '0;
`ifdef STORE_MISALIGN_CHK_EN
    assign out_misalign[l] = main_valid && main_q.mis;
`endif
  end

endmodule
